clkdiv_cfg_ctrl: RTL and testbench

Configuration controller for the integer clock divider. It arbitrates ratio-change requests from two requesters (0 = system controller, 1 = register file) and sequences each change safely. For every accepted change it gates the divider, quiesces, loads the new ratio, settles, then re-enables. It drives the divider's enable and ratio inputs and owns the only copy of the active ratio.

---
 rtl/clkdiv_cfg_ctrl.sv | 156 +++++++++++++++
 tb/tb_clkdiv_cfg_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_cfg_ctrl.sv
// Ratio-change sequencer for the integer clock divider: arbitrates two requesters
// and walks each accepted change through gate / quiesce / load / settle / re-enable.
module clkdiv_cfg_ctrl #(
    parameter int WIDTH       = 8,
    parameter int QUIESCE_CYC = 2,
    parameter int SETTLE_CYC  = 2,
    parameter int RESET_RATIO = 1
) (
    input  logic             i_ref_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_req0,
    input  logic [WIDTH-1:0] i_ratio0,
    input  logic             i_req1,
    input  logic [WIDTH-1:0] i_ratio1,
    output logic             o_ack0,
    output logic             o_ack1,
    output logic             o_err,
    output logic             o_busy,
    output logic             o_div_en,
    output logic [WIDTH-1:0] o_div_ratio
);

    localparam int MAX_CYC = (QUIESCE_CYC > SETTLE_CYC) ? QUIESCE_CYC : SETTLE_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    // The settle window is SETTLE_CYC cycles of new ratio with the divider gated;
    // the DONE cycle is the last of them, so SETTLE itself holds one cycle fewer.
    localparam logic [CW-1:0]    Q_LOAD    = CW'(QUIESCE_CYC - 1);
    localparam logic [CW-1:0]    S_LOAD    = CW'((SETTLE_CYC >= 2) ? SETTLE_CYC - 2 : 0);
    localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_RATIO);
    localparam logic [WIDTH-1:0] BYPASS_LIM = WIDTH'(2);

    typedef enum logic [2:0] {IDLE, GATE, LOAD, SETTLE, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             ptr_reg, ptr_next;
    logic [WIDTH-1:0] lat_ratio_reg, lat_ratio_next;
    logic             lat_id_reg, lat_id_next;
    logic [WIDTH-1:0] ratio_reg, ratio_next;
    logic             div_en_reg, div_en_next;
    logic             ack0_reg, ack0_next;
    logic             ack1_reg, ack1_next;
    logic             err_reg, err_next;
    logic             busy_reg, busy_next;

    logic             any_req;
    logic             grant_id;
    logic [WIDTH-1:0] grant_ratio;

    // Contention goes to the pointer; a lone request always wins.
    assign any_req     = i_req0 | i_req1;
    assign grant_id    = (i_req0 & i_req1) ? ptr_reg : i_req1;
    assign grant_ratio = grant_id ? i_ratio1 : i_ratio0;

    always_ff @(posedge i_ref_clk) begin
        if (!i_rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            ptr_reg       <= 1'b0;
            lat_ratio_reg <= RESET_VAL;
            lat_id_reg    <= 1'b0;
            ratio_reg     <= RESET_VAL;
            div_en_reg    <= 1'b0;
            ack0_reg      <= 1'b0;
            ack1_reg      <= 1'b0;
            err_reg       <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            ptr_reg       <= ptr_next;
            lat_ratio_reg <= lat_ratio_next;
            lat_id_reg    <= lat_id_next;
            ratio_reg     <= ratio_next;
            div_en_reg    <= div_en_next;
            ack0_reg      <= ack0_next;
            ack1_reg      <= ack1_next;
            err_reg       <= err_next;
            busy_reg      <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (any_req && (grant_ratio != '0) && (grant_ratio != ratio_reg))
                    state_next = GATE;
            end
            GATE:    if (cnt_reg == '0) state_next = LOAD;
            LOAD:    state_next = (SETTLE_CYC > 1) ? SETTLE : DONE;
            SETTLE:  if (cnt_reg == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cnt_next       = cnt_reg;
        ptr_next       = ptr_reg;
        lat_ratio_next = lat_ratio_reg;
        lat_id_next    = lat_id_reg;
        ratio_next     = ratio_reg;
        div_en_next    = 1'b0;
        ack0_next      = 1'b0;
        ack1_next      = 1'b0;
        err_next       = 1'b0;
        busy_next      = (state_next != IDLE);
        case (state_reg)
            IDLE: begin
                div_en_next = i_en && (ratio_reg >= BYPASS_LIM);
                if (any_req) begin
                    ptr_next       = ~grant_id;
                    lat_ratio_next = grant_ratio;
                    lat_id_next    = grant_id;
                    if (grant_ratio == '0 || grant_ratio == ratio_reg) begin
                        err_next  = (grant_ratio == '0);
                        ack0_next = ~grant_id;
                        ack1_next = grant_id;
                    end else begin
                        div_en_next = 1'b0;
                        cnt_next    = Q_LOAD;
                    end
                end
            end
            GATE: begin
                if (cnt_reg != '0) cnt_next = cnt_reg - CW'(1);
            end
            LOAD: begin
                ratio_next = lat_ratio_reg;
                cnt_next   = S_LOAD;
            end
            SETTLE: begin
                if (cnt_reg != '0) cnt_next = cnt_reg - CW'(1);
            end
            DONE: begin
                ack0_next   = ~lat_id_reg;
                ack1_next   = lat_id_reg;
                div_en_next = i_en && (lat_ratio_reg >= BYPASS_LIM);
            end
            default: begin
                div_en_next = 1'b0;
            end
        endcase
    end

    assign o_ack0      = ack0_reg;
    assign o_ack1      = ack1_reg;
    assign o_err       = err_reg;
    assign o_busy      = busy_reg;
    assign o_div_en    = div_en_reg;
    assign o_div_ratio = ratio_reg;

endmodule

// File: tb/tb_clkdiv_cfg_ctrl.sv
// Directed bench for clkdiv_cfg_ctrl: a vector table of single requests plus
// hand-written sequences for timing, arbitration, enable and reset corners.
module tb_clkdiv_cfg_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         req0, req1;
    logic [W-1:0] ratio0, ratio1;
    logic         ack0, ack1, err, busy, div_en;
    logic [W-1:0] div_ratio;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    clkdiv_cfg_ctrl #(
        .WIDTH(W), .QUIESCE_CYC(2), .SETTLE_CYC(2), .RESET_RATIO(1)
    ) dut (
        .i_ref_clk  (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_req0     (req0),
        .i_ratio0   (ratio0),
        .i_req1     (req1),
        .i_ratio1   (ratio1),
        .o_ack0     (ack0),
        .o_ack1     (ack1),
        .o_err      (err),
        .o_busy     (busy),
        .o_div_en   (div_en),
        .o_div_ratio(div_ratio)
    );

    typedef struct {
        logic         id;
        logic [W-1:0] ratio;
        logic         en;
        int           lat;
        logic         err;
        logic [W-1:0] ratio_out;
        logic         den;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_ack(input string name, output int lat);
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            lat++;
            chk(name, {31'b0, ack0 & ack1}, 32'd0);
            if (ack0 || ack1) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s_timeout: no ack within 20 cycles, ack required", name);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        chk("rst_ratio", div_ratio, 1);
        chk("rst_den", div_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_acks", {ack0, ack1, err}, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        int lat;
        vecs[0] = '{1'b1, 8'd4,   1'b1, 1, 1'b0, 8'd4,   1'b1};
        vecs[1] = '{1'b0, 8'd0,   1'b1, 1, 1'b1, 8'd4,   1'b1};
        vecs[2] = '{1'b1, 8'd1,   1'b1, 6, 1'b0, 8'd1,   1'b0};
        vecs[3] = '{1'b0, 8'd1,   1'b1, 1, 1'b0, 8'd1,   1'b0};
        vecs[4] = '{1'b1, 8'd0,   1'b1, 1, 1'b1, 8'd1,   1'b0};
        vecs[5] = '{1'b0, 8'd255, 1'b1, 6, 1'b0, 8'd255, 1'b1};
        vecs[6] = '{1'b1, 8'd2,   1'b0, 6, 1'b0, 8'd2,   1'b0};
        vecs[7] = '{1'b0, 8'd2,   1'b1, 1, 1'b0, 8'd2,   1'b1};
        vecs[8] = '{1'b1, 8'd8,   1'b1, 6, 1'b0, 8'd8,   1'b1};

        en = 1'b1; req0 = 1'b0; req1 = 1'b0; ratio0 = '0; ratio1 = '0;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            step();
            chk("bypass_den", div_en, 0);
        end
        $display("txn reset: ratio=%0d den=%0d busy=%0d", div_ratio, div_en, busy);

        // Full sequence, cycle by cycle
        req0 = 1'b1; ratio0 = 8'd4;
        for (int c = 1; c <= 6; c++) begin
            step();
            chk("seqA_den", div_en, (c == 6));
            chk("seqA_ratio", div_ratio, (c >= 4) ? 4 : 1);
            chk("seqA_busy", busy, (c <= 5));
            chk("seqA_ack0", ack0, (c == 6));
            chk("seqA_ack1", ack1, 0);
        end
        req0 = 1'b0;
        $display("txn seqA: req0 ratio=4 -> ratio=%0d den=%0d", div_ratio, div_en);
        step();

        for (int i = 0; i < 9; i++) begin
            en = vecs[i].en;
            if (vecs[i].id) begin req1 = 1'b1; ratio1 = vecs[i].ratio; end
            else            begin req0 = 1'b1; ratio0 = vecs[i].ratio; end
            wait_ack("vec_mutex", lat);
            chk("vec_lat", lat, vecs[i].lat);
            chk("vec_ack_self", vecs[i].id ? ack1 : ack0, 1);
            chk("vec_ack_other", vecs[i].id ? ack0 : ack1, 0);
            chk("vec_err", err, vecs[i].err);
            chk("vec_ratio", div_ratio, vecs[i].ratio_out);
            chk("vec_den", div_en, vecs[i].den);
            $display("txn vec%0d: id=%0d ratio_in=%0d lat=%0d err=%0d ratio=%0d den=%0d",
                     i, vecs[i].id, vecs[i].ratio, lat, err, div_ratio, div_en);
            req0 = 1'b0; req1 = 1'b0;
            step();
        end

        // Enable follows i_en in IDLE with one cycle of latency
        en = 1'b0;
        chk("entog_before", div_en, 1);
        step();
        chk("entog_fall", div_en, 0);
        en = 1'b1;
        step();
        chk("entog_rise", div_en, 1);
        $display("txn en_toggle: den=%0d", div_en);

        // Enable dropped during SETTLE
        req0 = 1'b1; ratio0 = 8'd5;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c == 4) begin
                chk("settle_busy", busy, 1);
                en = 1'b0;
            end
        end
        chk("settle_ack0", ack0, 1);
        chk("settle_den", div_en, 0);
        chk("settle_ratio", div_ratio, 5);
        req0 = 1'b0; en = 1'b1;
        step();
        chk("settle_den_back", div_en, 1);
        $display("txn en_drop_settle: ratio=%0d den=%0d", div_ratio, div_en);

        // Arbitration from reset: pointer starts at requester 0
        do_reset();
        req0 = 1'b1; ratio0 = 8'd6; req1 = 1'b1; ratio1 = 8'd3;
        wait_ack("arb1a_mutex", lat);
        chk("arb1a_lat", lat, 6);
        chk("arb1a_ack0", ack0, 1);
        chk("arb1a_ratio", div_ratio, 6);
        req0 = 1'b0;
        wait_ack("arb1b_mutex", lat);
        chk("arb1b_lat", lat, 6);
        chk("arb1b_ack1", ack1, 1);
        chk("arb1b_ratio", div_ratio, 3);
        req1 = 1'b0;
        $display("txn arb1: req0 then req1, ratio=%0d", div_ratio);
        step();

        req0 = 1'b1; ratio0 = 8'd9; req1 = 1'b1; ratio1 = 8'd5;
        wait_ack("arb2a_mutex", lat);
        chk("arb2a_ack0", ack0, 1);
        chk("arb2a_ratio", div_ratio, 9);
        ratio0 = 8'd7;
        wait_ack("arb2b_mutex", lat);
        chk("arb2b_lat", lat, 6);
        chk("arb2b_ack1", ack1, 1);
        chk("arb2b_ratio", div_ratio, 5);
        req1 = 1'b0;
        wait_ack("arb2c_mutex", lat);
        chk("arb2c_ack0", ack0, 1);
        chk("arb2c_ratio", div_ratio, 7);
        req0 = 1'b0;
        $display("txn arb2: req0, contended req1 first, then req0 ratio=%0d", div_ratio);
        step();

        // Reset during GATE aborts without ack; held request is re-accepted
        req1 = 1'b1; ratio1 = 8'd4;
        step();
        chk("rstg_busy", busy, 1);
        rst_n = 1'b0;
        step();
        chk("rstg_busy_after", busy, 0);
        chk("rstg_ratio", div_ratio, 1);
        chk("rstg_ack1", ack1, 0);
        chk("rstg_den", div_en, 0);
        rst_n = 1'b1;
        wait_ack("rstg_mutex", lat);
        chk("rstg_lat", lat, 6);
        chk("rstg_reack1", ack1, 1);
        chk("rstg_reratio", div_ratio, 4);
        chk("rstg_reden", div_en, 1);
        req1 = 1'b0;
        $display("txn reset_gate: re-accepted ratio=%0d", div_ratio);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, test end required");
        $fatal(1, "watchdog");
    end

endmodule
